// File: rtl/iic_byte_master.sv
// Purpose : byte-oriented I2C master; one register write or read burst per accepted trigger.
// Latency : bus activity starts the cycle after acceptance; writes add T_WR ms of settle time before busy drops.
// Backpress: triggers are dropped while busy; the bus always runs to completion (slave NACK is not acted on).
//
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   device_id, w_r        - slave address in [7:1], direction (1 = write, 0 = read)
//   pluse, byte_len       - start trigger and number of data words (0 = ignore trigger)
//   addr, data_in         - register address (MSB byte first) and current write word
//   busy, byte_over       - transaction/settle in progress, one-cycle strobe per completed data word
//   data_out              - last word read from the slave
//   scl, sda_out,
//   sda_out_en, sda_in    - I2C clock (push-pull) and SDA drive/enable/pad level
module iic_byte_master #(
  parameter int CLK_FRE   = 50_000_000,
  parameter int IIC_FREQ  = 400_000,
  parameter int T_WR      = 5,
  parameter int ADDR_BYTE = 1,
  parameter int LEN_WIDTH = 3,
  parameter int DATA_BYTE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             device_id,
  input  logic                   pluse,
  input  logic                   w_r,
  input  logic [LEN_WIDTH:0]     byte_len,
  input  logic [8*ADDR_BYTE-1:0] addr,
  input  logic [8*DATA_BYTE-1:0] data_in,
  output logic                   busy,
  output logic                   byte_over,
  output logic [8*DATA_BYTE-1:0] data_out,
  output logic                   scl,
  input  logic                   sda_in,
  output logic                   sda_out,
  output logic                   sda_out_en
);

  // Quarter-bit period in clocks (truncated), forced to at least one clock.
  localparam int Q_RAW = CLK_FRE / (4 * IIC_FREQ);
  localparam int Q     = (Q_RAW < 1) ? 1 : Q_RAW;
  localparam int QW    = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [QW-1:0] Q_LAST = QW'(Q - 1);

  // Post-write settle time in clocks; clock rates are whole kHz so this equals T_WR*CLK_FRE/1000.
  localparam int TW_RAW = T_WR * (CLK_FRE / 1000);
  localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam int TWW    = (TW > 1) ? $clog2(TW) : 1;
  localparam logic [TWW-1:0] TW_LAST = TWW'(TW - 1);

  localparam int LW = LEN_WIDTH + 1;
  localparam int AW = 8 * ADDR_BYTE;
  localparam int DW = 8 * DATA_BYTE;
  localparam logic [7:0] A_LAST = 8'(ADDR_BYTE - 1);
  localparam logic [7:0] D_LAST = 8'(DATA_BYTE - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV, S_ADDR, S_WDATA, S_RSTART, S_DEVR, S_RDATA, S_STOP, S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;     // clock within the current quarter
  logic [1:0]      qph_q, qph_d;       // quarter within the current bit time
  logic [3:0]      bcnt_q, bcnt_d;     // bit within byte, 8 = ACK/NACK slot
  logic [7:0]      byte_q, byte_d;     // byte within address field or data word
  logic [LW-1:0]   word_q, word_d;     // data word within the burst
  logic [TWW-1:0]  wait_q, wait_d;
  logic [6:0]      dev_q, dev_d;
  logic            wr_q, wr_d;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wword_q, wword_d;
  logic [DW-1:0]   rxw_q, rxw_d;
  logic [DW-1:0]   data_out_q, data_out_d;
  logic            byte_over_q, byte_over_d;
  logic            busy_q, busy_d;
  logic            scl_q, scl_d;
  logic            sda_q, sda_d;
  logic            sda_en_q, sda_en_d;

  logic            q_end, bit_end, last_byte, last_rd;
  logic [7:0]      tx_byte;
  logic [AW-1:0]   a_shift;
  logic [DW-1:0]   w_shift;

  // The R/W bit is generated here, so the LSB of device_id is never needed.
  logic unused_dev_lsb;
  assign unused_dev_lsb = device_id[0];

  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    qph_d       = qph_q;
    bcnt_d      = bcnt_q;
    byte_d      = byte_q;
    word_d      = word_q;
    wait_d      = wait_q;
    dev_d       = dev_q;
    wr_d        = wr_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wword_d     = wword_q;
    rxw_d       = rxw_q;
    data_out_d  = data_out_q;
    byte_over_d = 1'b0;
    q_end       = (qcnt_q == Q_LAST);
    bit_end     = q_end && (qph_q == 2'd3);
    last_byte   = 1'b1;
    last_rd     = 1'b0;
    tx_byte     = 8'hFF;
    a_shift     = '0;
    w_shift     = '0;

    case (state_q)
      S_IDLE: begin
        if (pluse && (byte_len != '0)) begin
          state_d = S_START;
          dev_d   = device_id[7:1];
          wr_d    = w_r;
          len_d   = byte_len;
          addr_d  = addr;
          qcnt_d  = '0;
          qph_d   = 2'd0;
          bcnt_d  = 4'd0;
          byte_d  = 8'd0;
          word_d  = '0;
        end
      end
      S_WAIT: begin
        if (wait_q == TW_LAST) state_d = S_IDLE;
        else                   wait_d  = wait_q + TWW'(1);
      end
      default: begin
        qcnt_d = q_end ? '0 : qcnt_q + QW'(1);
        if (q_end) qph_d = qph_q + 2'd1;
        // Read data is captured at the q2->q3 boundary, mid SCL-high.
        if ((state_q == S_RDATA) && q_end && (qph_q == 2'd2) && (bcnt_q != 4'd8))
          rxw_d = {rxw_q[DW-2:0], sda_in};
        if (bit_end) begin
          case (state_q)
            S_START:  state_d = S_DEV;
            S_RSTART: state_d = S_DEVR;
            S_STOP: begin
              state_d = wr_q ? S_WAIT : S_IDLE;
              wait_d  = '0;
            end
            default: begin
              if (bcnt_q != 4'd8) begin
                bcnt_d = bcnt_q + 4'd1;
              end else begin
                bcnt_d = 4'd0;
                if (state_q == S_ADDR)
                  last_byte = (byte_q == A_LAST);
                else if ((state_q == S_WDATA) || (state_q == S_RDATA))
                  last_byte = (byte_q == D_LAST);
                if (!last_byte) begin
                  byte_d = byte_q + 8'd1;
                end else begin
                  byte_d = 8'd0;
                  case (state_q)
                    S_DEV:  state_d = S_ADDR;
                    S_ADDR: state_d = wr_q ? S_WDATA : S_RSTART;
                    S_DEVR: state_d = S_RDATA;
                    default: begin
                      // End of a data word: strobe, publish read data, next word or STOP.
                      byte_over_d = 1'b1;
                      if (state_q == S_RDATA) data_out_d = rxw_q;
                      if (word_q == len_q - LW'(1)) begin
                        word_d  = '0;
                        state_d = S_STOP;
                      end else begin
                        word_d = word_q + LW'(1);
                      end
                    end
                  endcase
                end
              end
            end
          endcase
        end
      end
    endcase

    // The write word keeps tracking data_in through the whole first quarter of the
    // word's first bit (SCL low), so a controller that updates data_in a few
    // clocks after byte_over still gets its new word onto the bus.
    if ((state_d == S_WDATA) && (byte_d == 8'd0) && (bcnt_d == 4'd0) && (qph_d == 2'd0))
      wword_d = data_in;

    case (state_d)
      S_DEV:   tx_byte = {dev_q, 1'b0};
      S_DEVR:  tx_byte = {dev_q, 1'b1};
      S_ADDR: begin
        a_shift = addr_q >> {A_LAST - byte_d, 3'b000};
        tx_byte = a_shift[7:0];
      end
      S_WDATA: begin
        w_shift = wword_d >> {D_LAST - byte_d, 3'b000};
        tx_byte = w_shift[7:0];
      end
      default: tx_byte = 8'hFF;
    endcase
    last_rd = (byte_d == D_LAST) && (word_d == len_q - LW'(1));

    // Bus outputs are derived from the next-state values so they are registered
    // yet aligned with the state they belong to.
    scl_d    = 1'b1;
    sda_d    = 1'b1;
    sda_en_d = 1'b1;
    case (state_d)
      S_START: sda_d = ~qph_d[1];
      S_RSTART: begin
        scl_d = (qph_d != 2'd0);
        sda_d = ~qph_d[1];
      end
      S_STOP: begin
        scl_d = (qph_d != 2'd0);
        sda_d = (qph_d == 2'd3);
      end
      S_DEV, S_ADDR, S_WDATA, S_DEVR, S_RDATA: begin
        scl_d = qph_d[1];
        if (bcnt_d == 4'd8) begin
          if (state_d == S_RDATA) sda_d    = last_rd;  // ACK=0, NACK on the final byte
          else                    sda_en_d = 1'b0;     // slave ACK slot
        end else if (state_d == S_RDATA) begin
          sda_en_d = 1'b0;
        end else begin
          sda_d = tx_byte[3'd7 - bcnt_d[2:0]];
        end
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      qcnt_q      <= '0;
      qph_q       <= 2'd0;
      bcnt_q      <= 4'd0;
      byte_q      <= 8'd0;
      word_q      <= '0;
      wait_q      <= '0;
      dev_q       <= 7'd0;
      wr_q        <= 1'b0;
      len_q       <= '0;
      addr_q      <= '0;
      wword_q     <= '0;
      rxw_q       <= '0;
      data_out_q  <= '0;
      byte_over_q <= 1'b0;
      busy_q      <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      sda_en_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      qph_q       <= qph_d;
      bcnt_q      <= bcnt_d;
      byte_q      <= byte_d;
      word_q      <= word_d;
      wait_q      <= wait_d;
      dev_q       <= dev_d;
      wr_q        <= wr_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wword_q     <= wword_d;
      rxw_q       <= rxw_d;
      data_out_q  <= data_out_d;
      byte_over_q <= byte_over_d;
      busy_q      <= busy_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      sda_en_q    <= sda_en_d;
    end
  end

  assign busy       = busy_q;
  assign byte_over  = byte_over_q;
  assign data_out   = data_out_q;
  assign scl        = scl_q;
  assign sda_out    = sda_q;
  assign sda_out_en = sda_en_q;

endmodule

// File: tb/tb_iic_byte_master.sv
// Purpose : directed bench for iic_byte_master with a bus-level I2C slave model.
// Latency : n/a (bench).
// Backpress: n/a (bench).
module tb_iic_byte_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  device_id;
  logic        pluse;
  logic        w_r;
  logic [3:0]  byte_len;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        busy, byte_over;
  logic [7:0]  data_out;
  logic        scl, sda_out, sda_out_en, sda_in;
  logic        slave_sda = 1'b1;

  always #5 clk = ~clk;

  assign sda_in = sda_out_en ? sda_out : slave_sda;

  iic_byte_master #(
    .CLK_FRE(10_000_000), .IIC_FREQ(400_000), .T_WR(1),
    .ADDR_BYTE(2), .LEN_WIDTH(3), .DATA_BYTE(1)
  ) dut (
    .clk(clk), .rst(rst), .device_id(device_id), .pluse(pluse), .w_r(w_r),
    .byte_len(byte_len), .addr(addr), .data_in(data_in), .busy(busy),
    .byte_over(byte_over), .data_out(data_out), .scl(scl), .sda_in(sda_in),
    .sda_out(sda_out), .sda_out_en(sda_out_en)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- bus monitor + slave model ----------------
  int         start_cnt, stop_cnt, rise_cnt, nbytes, nacks;
  logic [7:0] blog [16];
  logic       alog [16];
  int         bitc = 0;
  int         bidx = 0;
  logic       rd_mode = 1'b0;
  logic [7:0] sh = 8'h00;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       mline;
  logic [7:0] rd_byte;
  logic       nack_addr;

  always @(negedge clk) begin
    mline = sda_in;
    if (prev_scl && scl && prev_sda && !mline) begin
      start_cnt++;
      bitc = 0; bidx = 0; rd_mode = 1'b0; slave_sda = 1'b1;
    end else if (prev_scl && scl && !prev_sda && mline) begin
      stop_cnt++;
    end
    if (!prev_scl && scl) begin
      rise_cnt++;
      if (bitc < 8) sh = {sh[6:0], mline};
      else if (nacks < 16) begin alog[nacks] = mline; nacks++; end
      bitc++;
    end else if (prev_scl && !scl) begin
      if (bitc == 8) begin
        if (nbytes < 16) blog[nbytes] = sh;
        nbytes++;
        if (bidx == 0) rd_mode = sh[0];
        if (rd_mode && bidx > 0) slave_sda = 1'b1;
        else slave_sda = (nack_addr && bidx == 1) ? 1'b1 : 1'b0;
      end else if (bitc >= 9) begin
        bitc = 0;
        bidx++;
        slave_sda = (rd_mode && bidx > 0) ? rd_byte[7] : 1'b1;
      end else if (rd_mode && bidx > 0) begin
        slave_sda = rd_byte[3'(7 - bitc)];
      end
    end
    prev_scl = scl;
    prev_sda = mline;
  end

  task automatic mon_clear();
    start_cnt = 0; stop_cnt = 0; rise_cnt = 0; nbytes = 0; nacks = 0;
  endtask

  // ---------------- transaction driver ----------------
  int         busy_cyc, bo_cnt, nw;
  logic [7:0] bo_data;
  logic       done, first_busy;
  logic [7:0] wv [4];
  logic [7:0] exp_b [8];

  task automatic run_txn(input logic wr, input logic [3:0] len, input int inj_cyc, input int max_cyc);
    mon_clear();
    busy_cyc = 0; bo_cnt = 0; bo_data = 8'h00; done = 1'b0; first_busy = 1'b0;
    w_r = wr; byte_len = len;
    pluse = 1'b1;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk);
      pluse = (c + 1 == inj_cyc);
      if (c == 0) first_busy = busy;
      if (busy) busy_cyc++;
      if (byte_over) begin
        bo_data = data_out;
        bo_cnt++;
        if (bo_cnt < nw) data_in = wv[bo_cnt];
      end
      if (c > 0 && !busy) done = 1'b1;
    end
    pluse = 1'b0;
    chk("txn_done", done, 1);
    chk("busy_rise", first_busy, 1);
  endtask

  task automatic chk_bytes(input string pfx, input int n);
    chk({pfx, "_nbytes"}, nbytes, n);
    for (int i = 0; i < n; i++) chk($sformatf("%s_b%0d", pfx, i), blog[i], exp_b[i]);
  endtask

  initial begin
    device_id = 8'hB2; pluse = 1'b0; w_r = 1'b1; byte_len = 4'd1;
    addr = 16'h1234; data_in = 8'h5A; rd_byte = 8'hC3; nack_addr = 1'b0;
    nw = 1; wv[0] = 8'h5A;
    mon_clear();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_byte_over", byte_over, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda_out, 1);
    chk("rst_sda_en", sda_out_en, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single-byte write
    run_txn(1'b1, 4'd1, -1, 15000);
    exp_b[0] = 8'hB2; exp_b[1] = 8'h12; exp_b[2] = 8'h34; exp_b[3] = 8'h5A;
    chk_bytes("wr", 4);
    chk("wr_busy_cyc", busy_cyc, 912 + 10000);
    chk("wr_start", start_cnt, 1);
    chk("wr_stop", stop_cnt, 1);
    chk("wr_scl_rise", rise_cnt, 37);
    chk("wr_byte_over", bo_cnt, 1);
    chk("wr_acks", nacks, 4);
    repeat (5) @(negedge clk);

    // Single-byte read
    run_txn(1'b0, 4'd1, -1, 5000);
    exp_b[3] = 8'hB3; exp_b[4] = 8'hC3;
    chk_bytes("rd", 5);
    chk("rd_start", start_cnt, 2);
    chk("rd_stop", stop_cnt, 1);
    chk("rd_scl_rise", rise_cnt, 47);
    chk("rd_busy_cyc", busy_cyc, 1152);
    chk("rd_byte_over", bo_cnt, 1);
    chk("rd_bo_data", bo_data, 8'hC3);
    chk("rd_data_out", data_out, 8'hC3);
    chk("rd_slave_ack", alog[3], 0);
    chk("rd_master_nack", alog[4], 1);
    repeat (5) @(negedge clk);

    // Burst write, with an extra trigger injected while busy
    nw = 3; wv[0] = 8'h11; wv[1] = 8'h22; wv[2] = 8'h33; data_in = 8'h11;
    run_txn(1'b1, 4'd3, 100, 15000);
    exp_b[3] = 8'h11; exp_b[4] = 8'h22; exp_b[5] = 8'h33;
    chk_bytes("burst", 6);
    chk("burst_byte_over", bo_cnt, 3);
    chk("burst_busy_cyc", busy_cyc, 1344 + 10000);
    chk("burst_start", start_cnt, 1);
    chk("burst_stop", stop_cnt, 1);
    nw = 1;
    repeat (5) @(negedge clk);

    // Trigger with byte_len=0 is ignored
    mon_clear();
    busy_cyc = 0;
    byte_len = 4'd0; pluse = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      pluse = 1'b0;
      if (busy) busy_cyc++;
    end
    chk("len0_busy", busy_cyc, 0);
    chk("len0_scl", rise_cnt, 0);
    chk("len0_start", start_cnt, 0);

    // Slave NACKs the first address byte on a read
    nack_addr = 1'b1; rd_byte = 8'h96;
    run_txn(1'b0, 4'd1, -1, 5000);
    exp_b[3] = 8'hB3; exp_b[4] = 8'h96;
    chk_bytes("nack", 5);
    chk("nack_seen", alog[1], 1);
    chk("nack_stop", stop_cnt, 1);
    chk("nack_bo_data", bo_data, 8'h96);
    chk("nack_busy_cyc", busy_cyc, 1152);
    nack_addr = 1'b0;
    repeat (5) @(negedge clk);

    // Reset in the middle of the first address byte
    w_r = 1'b1; byte_len = 4'd1; data_in = 8'h5A; pluse = 1'b1;
    @(negedge clk);
    pluse = 1'b0;
    repeat (300) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_scl", scl, 1);
    chk("mid_rst_sda", sda_out, 1);
    chk("mid_rst_sda_en", sda_out_en, 1);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rd_byte = 8'h5A;
    run_txn(1'b0, 4'd1, -1, 5000);
    exp_b[3] = 8'hB3; exp_b[4] = 8'h5A;
    chk_bytes("post_rst", 5);
    chk("post_rst_bo_data", bo_data, 8'h5A);
    chk("post_rst_busy_cyc", busy_cyc, 1152);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
